lfsr_checker: RTL and testbench

LFSR_CHECKER -- requirements
Module: lfsr_checker

---
 rtl/lfsr_checker.sv | 142 ++++++++++++++
 tb/tb_lfsr_checker.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Locks onto a 4-bit LFSR stream (x -> {x[2:0], x[3]^x[0]}) and flags words that break the sequence.
// Define LFSR_CHECKER_STATS_EN to enable the saturating err_count and clr_count.
module lfsr_checker #(
  parameter int unsigned LOCK_CNT   = 3,
  parameter int unsigned UNLOCK_CNT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [3:0]  in_data,
  input  logic        clr_count,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count
);

  localparam int unsigned OkW  = $clog2(LOCK_CNT + 1);
  localparam int unsigned BadW = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

  function automatic logic [3:0] lfsr_next(input logic [3:0] x);
    return {x[2:0], x[3] ^ x[0]};
  endfunction

  state_e          state_q, state_d;
  logic [3:0]      prev_q, prev_d;
  logic [OkW-1:0]  ok_cnt_q, ok_cnt_d;
  logic [BadW-1:0] bad_cnt_q, bad_cnt_d;
  logic            locked_q, locked_d;
  logic            err_pulse_q, err_pulse_d;
  logic [3:0]      pred;
  logic            match;
  logic            err_evt;
  logic            unlock_evt;

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    ok_cnt_d    = ok_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    err_evt     = 1'b0;
    unlock_evt  = 1'b0;
    pred        = lfsr_next(prev_q);
    match       = (in_data == pred);

    if (in_valid) begin
      unique case (state_q)
        StSearch: begin
          if (in_data != 4'h0) begin
            prev_d   = in_data;
            ok_cnt_d = '0;
            state_d  = StVerify;
          end
        end
        StVerify: begin
          if (match) begin
            prev_d   = in_data;
            ok_cnt_d = ok_cnt_q + 1'b1;
            if (ok_cnt_q == OkW'(LOCK_CNT - 1)) state_d = StLocked;
          end else if (in_data == 4'h0) begin
            state_d = StSearch;
          end else begin
            prev_d   = in_data;
            ok_cnt_d = '0;
          end
        end
        StLocked: begin
          if (match) begin
            prev_d    = in_data;
            bad_cnt_d = '0;
          end else begin
            // Flywheel: keep tracking the predicted sequence through the bad word.
            prev_d  = pred;
            err_evt = 1'b1;
            if (bad_cnt_q == BadW'(UNLOCK_CNT - 1)) begin
              unlock_evt = 1'b1;
              bad_cnt_d  = '0;
              state_d    = StSearch;
            end else begin
              bad_cnt_d = bad_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = StSearch;
      endcase
    end

    // locked stays high for the cycle that reports the unlocking mismatch.
    locked_d    = (state_d == StLocked) || unlock_evt;
    err_pulse_d = err_evt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StSearch;
      prev_q      <= 4'h0;
      ok_cnt_q    <= '0;
      bad_cnt_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      ok_cnt_q    <= ok_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;

`ifdef LFSR_CHECKER_STATS_EN
  logic [15:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (clr_count) begin
      err_count_d = err_evt ? 16'd1 : 16'd0;
    end else if (err_evt && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_q <= 16'd0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  logic unused_clr_count;
  assign unused_clr_count = clr_count;
  assign err_count        = 16'd0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: scoreboarded steps on a default instance plus a
// long-unlock instance used to drive err_count into saturation.
module tb_lfsr_checker;

  logic        clk;
  logic        reset;
  logic        in_valid, in_valid2;
  logic [3:0]  in_data, in_data2;
  logic        clr_count, clr_count2;
  logic        locked, locked2;
  logic        err_pulse, err_pulse2;
  logic [15:0] err_count, err_count2;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        l;
    logic        p;
    logic [15:0] c;
  } exp_t;

  exp_t sb[$];

  lfsr_checker #(
    .LOCK_CNT  (3),
    .UNLOCK_CNT(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .clr_count(clr_count),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_count(err_count)
  );

  lfsr_checker #(
    .LOCK_CNT  (3),
    .UNLOCK_CNT(70000)
  ) dut_sat (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid2),
    .in_data  (in_data2),
    .clr_count(clr_count2),
    .locked   (locked2),
    .err_pulse(err_pulse2),
    .err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ec(input int n);
`ifdef LFSR_CHECKER_STATS_EN
    return 16'(n);
`else
    return 16'(n * 0);
`endif
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] d, input logic c, input logic el,
                      input logic ep, input logic [15:0] ecnt, input string tag);
    exp_t e;
    in_valid  = v;
    in_data   = d;
    clr_count = c;
    e.l = el;
    e.p = ep;
    e.c = ecnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".locked"}, {15'd0, locked}, {15'd0, e.l});
    chk({tag, ".err_pulse"}, {15'd0, err_pulse}, {15'd0, e.p});
    chk({tag, ".err_count"}, err_count, e.c);
  endtask

  task automatic drive2(input logic v, input logic [3:0] d, input logic c);
    in_valid2  = v;
    in_data2   = d;
    clr_count2 = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = 4'h0;
    clr_count  = 1'b0;
    in_valid2  = 1'b0;
    in_data2   = 4'h0;
    clr_count2 = 1'b0;

    // Reset held with in_valid toggling.
    for (int i = 0; i < 4; i++) step(1'(i % 2), 4'(i * 5 + 1), 1'b0, 1'b0, 1'b0, ec(0), "rst");
    reset = 1'b0;

    // Acquisition.
    step(1, 4'h1, 0, 0, 0, ec(0), "acq1");
    step(1, 4'h3, 0, 0, 0, ec(0), "acq3");
    step(1, 4'h7, 0, 0, 0, ec(0), "acq7");
    step(1, 4'hF, 0, 1, 0, ec(0), "acq_lock");
    step(0, 4'h9, 0, 1, 0, ec(0), "idle_hold");

    // Single corrupted word, then continued tracking.
    step(1, 4'hE, 0, 1, 0, ec(0), "se_E");
    step(1, 4'h0, 0, 1, 1, ec(1), "se_err");
    step(1, 4'hA, 0, 1, 0, ec(1), "se_A");
    step(1, 4'h5, 0, 1, 0, ec(1), "se_5");

    // Isolated errors separated by matches never unlock.
    step(1, 4'h0, 0, 1, 1, ec(2), "iso_err1");
    step(1, 4'h6, 0, 1, 0, ec(2), "iso_6");
    step(1, 4'h0, 0, 1, 1, ec(3), "iso_err2");
    step(1, 4'h9, 0, 1, 0, ec(3), "iso_9");

    // Two consecutive errors lose lock.
    step(1, 4'h5, 0, 1, 1, ec(4), "lol_1");
    step(1, 4'h5, 0, 1, 1, ec(5), "lol_2");
    step(0, 4'h5, 0, 0, 0, ec(5), "lol_low");
    step(1, 4'h0, 0, 0, 0, ec(5), "search_z1");
    step(1, 4'h0, 0, 0, 0, ec(5), "search_z2");

    // VERIFY mismatch reseeds without counting.
    step(1, 4'h1, 0, 0, 0, ec(5), "rs_1");
    step(1, 4'h3, 0, 0, 0, ec(5), "rs_3");
    step(1, 4'h5, 0, 0, 0, ec(5), "rs_5");
    step(1, 4'hB, 0, 0, 0, ec(5), "rs_B");
    step(1, 4'h6, 0, 0, 0, ec(5), "rs_6");
    step(1, 4'hC, 0, 1, 0, ec(5), "rs_lock");

    // clr_count with and without a simultaneous error.
    step(1, 4'h0, 1, 1, 1, ec(1), "clr_err");
    step(1, 4'h2, 0, 1, 0, ec(1), "clr_2");
    step(1, 4'h4, 1, 1, 0, ec(0), "clr_only");

    // Reset mid-lock discards lock; reacquire with idle gaps.
    reset = 1'b1;
    step(1, 4'h8, 0, 0, 0, ec(0), "mid_rst");
    reset = 1'b0;
    step(1, 4'h1, 0, 0, 0, ec(0), "gap_1");
    step(0, 4'h0, 0, 0, 0, ec(0), "gap_i1");
    step(1, 4'h3, 0, 0, 0, ec(0), "gap_3");
    step(0, 4'h5, 0, 0, 0, ec(0), "gap_i2");
    step(1, 4'h7, 0, 0, 0, ec(0), "gap_7");
    step(0, 4'hA, 0, 0, 0, ec(0), "gap_i3");
    step(1, 4'hF, 0, 1, 0, ec(0), "gap_lock");
    step(0, 4'h3, 0, 1, 0, ec(0), "gap_hold");

    // Zero word in VERIFY returns to SEARCH.
    reset = 1'b1;
    step(0, 4'h0, 0, 0, 0, ec(0), "zv_rst");
    reset = 1'b0;
    step(1, 4'h1, 0, 0, 0, ec(0), "zv_1");
    step(1, 4'h3, 0, 0, 0, ec(0), "zv_3");
    step(1, 4'h7, 0, 0, 0, ec(0), "zv_7");
    step(1, 4'h0, 0, 0, 0, ec(0), "zv_zero");
    step(1, 4'hF, 0, 0, 0, ec(0), "zv_F");
    step(1, 4'hE, 0, 0, 0, ec(0), "zv_E");
    step(1, 4'hD, 0, 0, 0, ec(0), "zv_D");
    step(1, 4'hA, 0, 1, 0, ec(0), "zv_lock");
    in_valid = 1'b0;

    // Saturation on the long-unlock instance.
    drive2(1, 4'h1, 0);
    drive2(1, 4'h3, 0);
    drive2(1, 4'h7, 0);
    drive2(1, 4'hF, 0);
    chk("sat_lock", {15'd0, locked2}, 16'd1);
    for (int i = 0; i < 65535; i++) drive2(1, 4'h0, 0);
    chk("sat_reach", err_count2, ec(65535));
    chk("sat_locked", {15'd0, locked2}, 16'd1);
    drive2(1, 4'h0, 0);
    drive2(1, 4'h0, 0);
    chk("sat_hold", err_count2, ec(65535));
    chk("sat_pulse", {15'd0, err_pulse2}, 16'd1);
    drive2(1, 4'h0, 1);
    chk("sat_clr_err", err_count2, ec(1));
    drive2(0, 4'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
